ipv4_rule_filter: RTL and testbench

- Parametrised, pipelined IPv4 header classifier with a run-time programmable rule table of NUM_RULES entries.
- Each entry matches masked source IP, masked destination IP and an optional protocol. The entry carries an accept/drop action.
- Sits between the header extractor and the app datapath. Emits one verdict per header over valid/ready handshakes.
- Adds header sanity checks: version == 4 and IHL >= 5.

---
 rtl/ipv4_rule_filter.sv | 222 ++++++++++++++++++++++
 tb/tb_ipv4_rule_filter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_rule_filter.sv
// ipv4_rule_filter: two-stage IPv4 header classifier with a programmable
// rule table. Stage 1 computes the per-rule match vector and the header sanity
// bit; stage 2 priority-encodes the lowest matching rule and registers the
// verdict.
// Optional statistics counters are enabled by defining IPV4_RULE_FILTER_STATS_EN.
//
// Handshake: a transfer happens on a clk edge where valid and ready are both
// high. ready never depends on valid of the same interface. Once m_valid is
// raised, the verdict holds steady until m_ready accepts it.
// Stage readiness:
//   ready2 = !v2 | m_ready
//   ready1 = !v1 | ready2
//   s_ready = ready1
module ipv4_rule_filter #(
    parameter int HDR_WIDTH      = 160,
    parameter int NUM_RULES      = 8,
    parameter int RULE_IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
    parameter bit DEFAULT_ACCEPT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [HDR_WIDTH-1:0]  s_hdr,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  m_accept,
    output logic                  m_hit,
    output logic [RULE_IDX_W-1:0] m_rule_idx,
    output logic                  m_bad_hdr,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  cfg_wr_en,
    input  logic [RULE_IDX_W-1:0] cfg_addr,
    input  logic                  cfg_enable,
    input  logic [31:0]           cfg_src_ip,
    input  logic [31:0]           cfg_src_mask,
    input  logic [31:0]           cfg_dst_ip,
    input  logic [31:0]           cfg_dst_mask,
    input  logic [7:0]            cfg_proto,
    input  logic                  cfg_proto_en,
    input  logic                  cfg_action
`ifdef IPV4_RULE_FILTER_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [31:0]           accept_cnt,
    output logic [31:0]           drop_cnt,
    output logic [31:0]           bad_hdr_cnt
`endif
);

    localparam logic [RULE_IDX_W:0] NUM_RULES_W = NUM_RULES[RULE_IDX_W:0];

    // Rule table
    logic [NUM_RULES-1:0] rule_en;
    logic [NUM_RULES-1:0] rule_proto_en;
    logic [NUM_RULES-1:0] rule_action;
    logic [31:0]          rule_src_ip   [NUM_RULES];
    logic [31:0]          rule_src_mask [NUM_RULES];
    logic [31:0]          rule_dst_ip   [NUM_RULES];
    logic [31:0]          rule_dst_mask [NUM_RULES];
    logic [7:0]           rule_proto    [NUM_RULES];

    // Pipeline state
    logic                 v1, v2;
    logic                 ready1, ready2;
    logic [NUM_RULES-1:0] match1;
    logic [NUM_RULES-1:0] act1;
    logic                 sane1;

    // Header fields
    logic [3:0]  hdr_ver;
    logic [3:0]  hdr_ihl;
    logic [7:0]  hdr_proto;
    logic [31:0] hdr_src;
    logic [31:0] hdr_dst;
    logic        hdr_sane;
    logic        cfg_in_range;
    logic        unused_hdr_bits;

    logic [NUM_RULES-1:0]  match_vec;
    logic                  win_hit;
    logic                  win_act;
    logic [RULE_IDX_W-1:0] win_idx;

    assign hdr_ver   = s_hdr[7:4];
    assign hdr_ihl   = s_hdr[3:0];
    assign hdr_proto = s_hdr[79:72];
    assign hdr_src   = s_hdr[127:96];
    assign hdr_dst   = s_hdr[159:128];
    assign hdr_sane  = (hdr_ver == 4'd4) && (hdr_ihl >= 4'd5);
    assign unused_hdr_bits = ^{s_hdr[95:80], s_hdr[71:8]};

    assign cfg_in_range = ({1'b0, cfg_addr} < NUM_RULES_W);

    assign ready2  = !v2 || m_ready;
    assign ready1  = !v1 || ready2;
    assign s_ready = ready1;
    assign m_valid = v2;

    // Rule table writes; out-of-range addresses are ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rule_en       <= '0;
            rule_proto_en <= '0;
            rule_action   <= '0;
            for (int i = 0; i < NUM_RULES; i++) begin
                rule_src_ip[i]   <= '0;
                rule_src_mask[i] <= '0;
                rule_dst_ip[i]   <= '0;
                rule_dst_mask[i] <= '0;
                rule_proto[i]    <= '0;
            end
        end else if (cfg_wr_en && cfg_in_range) begin
            rule_en[cfg_addr]       <= cfg_enable;
            rule_proto_en[cfg_addr] <= cfg_proto_en;
            rule_action[cfg_addr]   <= cfg_action;
            rule_src_ip[cfg_addr]   <= cfg_src_ip;
            rule_src_mask[cfg_addr] <= cfg_src_mask;
            rule_dst_ip[cfg_addr]   <= cfg_dst_ip;
            rule_dst_mask[cfg_addr] <= cfg_dst_mask;
            rule_proto[cfg_addr]    <= cfg_proto;
        end
    end

    // Per-rule match of the incoming header against the current table
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_RULES; i++) begin
            match_vec[i] = rule_en[i]
                && (((hdr_src ^ rule_src_ip[i]) & rule_src_mask[i]) == 32'd0)
                && (((hdr_dst ^ rule_dst_ip[i]) & rule_dst_mask[i]) == 32'd0)
                && (!rule_proto_en[i] || (hdr_proto == rule_proto[i]));
        end
    end

    // Stage 1: capture match vector, sanity bit and the actions they refer to,
    // so a later table write cannot change an in-flight verdict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            match1 <= '0;
            act1   <= '0;
            sane1  <= 1'b0;
        end else if (ready1) begin
            v1 <= s_valid;
            if (s_valid) begin
                match1 <= match_vec;
                act1   <= rule_action;
                sane1  <= hdr_sane;
            end
        end
    end

    // Priority encoder: lowest matching index wins
    always_comb begin
        win_hit = 1'b0;
        win_act = 1'b0;
        win_idx = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (match1[i]) begin
                win_hit = 1'b1;
                win_act = act1[i];
                win_idx = RULE_IDX_W'(i);
            end
        end
    end

    // Stage 2: registered verdict, held while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2         <= 1'b0;
            m_accept   <= 1'b0;
            m_hit      <= 1'b0;
            m_rule_idx <= '0;
            m_bad_hdr  <= 1'b0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1) begin
                if (!sane1) begin
                    m_bad_hdr  <= 1'b1;
                    m_accept   <= 1'b0;
                    m_hit      <= 1'b0;
                    m_rule_idx <= '0;
                end else if (win_hit) begin
                    m_bad_hdr  <= 1'b0;
                    m_accept   <= win_act;
                    m_hit      <= 1'b1;
                    m_rule_idx <= win_idx;
                end else begin
                    m_bad_hdr  <= 1'b0;
                    m_accept   <= DEFAULT_ACCEPT;
                    m_hit      <= 1'b0;
                    m_rule_idx <= '0;
                end
            end
        end
    end

`ifdef IPV4_RULE_FILTER_STATS_EN
    logic out_fire;
    assign out_fire = v2 && m_ready;

    // Saturating verdict counters; clear wins over a coincident count
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            accept_cnt  <= '0;
            drop_cnt    <= '0;
            bad_hdr_cnt <= '0;
        end else if (out_fire) begin
            if (m_accept && (accept_cnt != 32'hFFFF_FFFF)) begin
                accept_cnt <= accept_cnt + 32'd1;
            end
            if (!m_accept && (drop_cnt != 32'hFFFF_FFFF)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
            if (m_bad_hdr && (bad_hdr_cnt != 32'hFFFF_FFFF)) begin
                bad_hdr_cnt <= bad_hdr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ipv4_rule_filter.sv
// Testbench for ipv4_rule_filter: table-driven vectors, hand sequences for
// latency, config race, backpressure and mid-operation reset, plus a random
// burst checked against a behavioural model through an expected-value queue.
`timescale 1ns/1ps
module tb_ipv4_rule_filter;

    localparam int NR  = 6;
    localparam int RIW = 3;
    localparam int EW  = RIW + 3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [159:0]   s_hdr;
    logic           s_valid;
    logic           s_ready;
    logic           m_accept;
    logic           m_hit;
    logic [RIW-1:0] m_rule_idx;
    logic           m_bad_hdr;
    logic           m_valid;
    logic           m_ready;
    logic           cfg_wr_en;
    logic [RIW-1:0] cfg_addr;
    logic           cfg_enable;
    logic [31:0]    cfg_src_ip;
    logic [31:0]    cfg_src_mask;
    logic [31:0]    cfg_dst_ip;
    logic [31:0]    cfg_dst_mask;
    logic [7:0]     cfg_proto;
    logic           cfg_proto_en;
    logic           cfg_action;
`ifdef IPV4_RULE_FILTER_STATS_EN
    logic           stats_clr;
    logic [31:0]    accept_cnt;
    logic [31:0]    drop_cnt;
    logic [31:0]    bad_hdr_cnt;
`endif

    ipv4_rule_filter #(
        .HDR_WIDTH(160), .NUM_RULES(NR), .RULE_IDX_W(RIW), .DEFAULT_ACCEPT(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_hdr(s_hdr), .s_valid(s_valid), .s_ready(s_ready),
        .m_accept(m_accept), .m_hit(m_hit), .m_rule_idx(m_rule_idx),
        .m_bad_hdr(m_bad_hdr), .m_valid(m_valid), .m_ready(m_ready),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_enable(cfg_enable),
        .cfg_src_ip(cfg_src_ip), .cfg_src_mask(cfg_src_mask),
        .cfg_dst_ip(cfg_dst_ip), .cfg_dst_mask(cfg_dst_mask),
        .cfg_proto(cfg_proto), .cfg_proto_en(cfg_proto_en), .cfg_action(cfg_action)
`ifdef IPV4_RULE_FILTER_STATS_EN
        ,
        .stats_clr(stats_clr), .accept_cnt(accept_cnt),
        .drop_cnt(drop_cnt), .bad_hdr_cnt(bad_hdr_cnt)
`endif
    );

    logic [EW-1:0] got_v;
    assign got_v = {m_accept, m_hit, m_rule_idx, m_bad_hdr};

    // scoreboard state
    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q[$];
    int n_acc = 0, n_drop = 0, n_bad = 0;

    // shadow rule table for the model
    logic [NR-1:0] sh_en, sh_pen, sh_act;
    logic [31:0]   sh_src [NR];
    logic [31:0]   sh_smask [NR];
    logic [31:0]   sh_dst [NR];
    logic [31:0]   sh_dmask [NR];
    logic [7:0]    sh_proto [NR];

    typedef struct {
        logic [3:0]     ver;
        logic [3:0]     ihl;
        logic [31:0]    src;
        logic [31:0]    dst;
        logic [7:0]     proto;
        logic           acc;
        logic           hit;
        logic [RIW-1:0] idx;
        logic           bad;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pack_exp(input logic a, input logic h,
                                               input logic [RIW-1:0] idx, input logic b);
        return {a, h, idx, b};
    endfunction

    function automatic logic [159:0] mk_hdr(input logic [3:0] ver, input logic [3:0] ihl,
                                            input logic [31:0] src, input logic [31:0] dst,
                                            input logic [7:0] proto);
        logic [159:0] h;
        for (int k = 0; k < 5; k++) h[k*32 +: 32] = $urandom();
        h[7:4]     = ver;
        h[3:0]     = ihl;
        h[79:72]   = proto;
        h[127:96]  = src;
        h[159:128] = dst;
        return h;
    endfunction

    // behavioural reference: sanity first, then first enabled matching rule
    function automatic logic [EW-1:0] model(input logic [159:0] h);
        if (!(h[7:4] == 4'd4 && h[3:0] >= 4'd5)) return pack_exp(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < NR; i++) begin
            if (sh_en[i]
                && (((h[127:96] ^ sh_src[i]) & sh_smask[i]) == 32'd0)
                && (((h[159:128] ^ sh_dst[i]) & sh_dmask[i]) == 32'd0)
                && (!sh_pen[i] || h[79:72] == sh_proto[i]))
                return pack_exp(sh_act[i], 1'b1, RIW'(i), 1'b0);
        end
        return pack_exp(1'b0, 1'b0, '0, 1'b0);
    endfunction

    task automatic shadow_clear();
        sh_en = '0; sh_pen = '0; sh_act = '0;
        for (int i = 0; i < NR; i++) begin
            sh_src[i] = '0; sh_smask[i] = '0; sh_dst[i] = '0; sh_dmask[i] = '0; sh_proto[i] = '0;
        end
    endtask

    task automatic shadow_write(input logic [RIW-1:0] addr, input logic en,
                                input logic [31:0] src, input logic [31:0] smask,
                                input logic [31:0] dst, input logic [31:0] dmask,
                                input logic [7:0] proto, input logic pen, input logic act);
        if (int'(addr) < NR) begin
            sh_en[addr] = en; sh_src[addr] = src; sh_smask[addr] = smask;
            sh_dst[addr] = dst; sh_dmask[addr] = dmask; sh_proto[addr] = proto;
            sh_pen[addr] = pen; sh_act[addr] = act;
        end
    endtask

    task automatic drive_cfg(input logic [RIW-1:0] addr, input logic en,
                             input logic [31:0] src, input logic [31:0] smask,
                             input logic [31:0] dst, input logic [31:0] dmask,
                             input logic [7:0] proto, input logic pen, input logic act);
        cfg_addr = addr; cfg_enable = en; cfg_src_ip = src; cfg_src_mask = smask;
        cfg_dst_ip = dst; cfg_dst_mask = dmask; cfg_proto = proto;
        cfg_proto_en = pen; cfg_action = act;
    endtask

    // driver tasks: all start and end at posedge + 1
    task automatic cfg_write(input logic [RIW-1:0] addr, input logic en,
                             input logic [31:0] src, input logic [31:0] smask,
                             input logic [31:0] dst, input logic [31:0] dmask,
                             input logic [7:0] proto, input logic pen, input logic act);
        drive_cfg(addr, en, src, smask, dst, dmask, proto, pen, act);
        cfg_wr_en = 1'b1;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        shadow_write(addr, en, src, smask, dst, dmask, proto, pen, act);
    endtask

    task automatic send_hdr(input logic [159:0] h, input logic [EW-1:0] e);
        int waited;
        bit done;
        waited = 0;
        done = 0;
        s_hdr = h;
        s_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back(e);
                done = 1;
            end else if (waited > 200) begin
                check("s_ready_timeout", 64'd0, 64'd1);
                done = 1;
            end
            waited++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        cfg_wr_en = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        shadow_clear();
        n_acc = 0; n_drop = 0; n_bad = 0;
    endtask

    // scoreboard monitor: pops on output handshakes, checks hold while stalled
    initial begin
        logic stall_prev;
        logic [EW-1:0] held;
        logic [EW-1:0] e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) check("stall_hold", {63'd0, m_valid} << EW | 64'(got_v),
                                      (64'd1 << EW) | 64'(held));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_verdict", 64'(got_v), 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("verdict", 64'(got_v), 64'(e));
                        if (e[EW-1]) n_acc++; else n_drop++;
                        if (e[0]) n_bad++;
                    end
                end
                stall_prev = m_valid && !m_ready;
                held = got_v;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // main test sequence
    initial begin
        logic [159:0] h;
        bit burst_done;

        rst_n = 1'b0; s_hdr = '0; s_valid = 1'b0; m_ready = 1'b1; cfg_wr_en = 1'b0;
        drive_cfg('0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
`ifdef IPV4_RULE_FILTER_STATS_EN
        stats_clr = 1'b0;
`endif
        do_reset();

        // reset state
        @(negedge clk);
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_s_ready", 64'(s_ready), 64'd1);
        check("reset_outputs", 64'(got_v), 64'd0);
        @(posedge clk); #1;

        // empty table, default drop, two-cycle latency
        h = mk_hdr(4'd4, 4'd5, 32'h0A000001, 32'hC0A80107, 8'h06);
        send_hdr(h, pack_exp(1'b0, 1'b0, '0, 1'b0));
        @(negedge clk); check("latency_cycle1", 64'(m_valid), 64'd0);
        @(negedge clk); check("latency_cycle2", 64'(m_valid), 64'd1);
        @(posedge clk); #1;
        drain();

        // writes beyond NUM_RULES are ignored
        cfg_write(3'd6, 1'b1, '0, '0, '0, '0, 8'h00, 1'b0, 1'b1);
        cfg_write(3'd7, 1'b1, '0, '0, '0, '0, 8'h00, 1'b0, 1'b1);
        send_hdr(h, pack_exp(1'b0, 1'b0, '0, 1'b0));
        drain();

        // config write in the same cycle as a handshake uses the old table
        drive_cfg(3'd0, 1'b1, '0, '0, '0, '0, 8'h00, 1'b0, 1'b1);
        cfg_wr_en = 1'b1;
        s_hdr = h;
        s_valid = 1'b1;
        @(negedge clk);
        check("race_s_ready", 64'(s_ready), 64'd1);
        exp_q.push_back(pack_exp(1'b0, 1'b0, '0, 1'b0));
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        s_valid = 1'b0;
        shadow_write(3'd0, 1'b1, '0, '0, '0, '0, 8'h00, 1'b0, 1'b1);
        send_hdr(h, pack_exp(1'b1, 1'b1, 3'd0, 1'b0));
        drain();
        cfg_write(3'd0, 1'b0, '0, '0, '0, '0, 8'h00, 1'b0, 1'b0);

        // rule set for the vector table
        cfg_write(3'd0, 1'b1, '0, '0, '0, '0, 8'h11, 1'b1, 1'b1);
        cfg_write(3'd1, 1'b1, '0, '0, 32'hC0A80107, 32'hFFFFFFFF, 8'h00, 1'b0, 1'b0);
        cfg_write(3'd3, 1'b1, 32'h0A000000, 32'hFF000000, '0, '0, 8'h00, 1'b0, 1'b1);
        cfg_write(3'd4, 1'b0, '0, '0, '0, '0, 8'h00, 1'b0, 1'b1);
        cfg_write(3'd5, 1'b1, 32'hC0000201, 32'hFFFFFFFF, '0, '0, 8'h06, 1'b1, 1'b0);

        vecs[0]  = '{4'd4, 4'd5,  32'h0A010203, 32'hC0A80107, 8'h06, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[1]  = '{4'd4, 4'd5,  32'h0A010203, 32'h01020304, 8'h06, 1'b1, 1'b1, 3'd3, 1'b0};
        vecs[2]  = '{4'd4, 4'd5,  32'h0B000001, 32'h01020304, 8'h06, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[3]  = '{4'd4, 4'd5,  32'h0B000001, 32'h01020304, 8'h11, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[4]  = '{4'd4, 4'd5,  32'h0A000001, 32'hC0A80107, 8'h11, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[5]  = '{4'd6, 4'd5,  32'h0A010203, 32'h01020304, 8'h06, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[6]  = '{4'd4, 4'd4,  32'h0A010203, 32'h01020304, 8'h06, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[7]  = '{4'd4, 4'd15, 32'h0A010203, 32'h01020304, 8'h06, 1'b1, 1'b1, 3'd3, 1'b0};
        vecs[8]  = '{4'd4, 4'd5,  32'hC0000201, 32'h05060708, 8'h06, 1'b0, 1'b1, 3'd5, 1'b0};
        vecs[9]  = '{4'd4, 4'd5,  32'hC0000201, 32'h05060708, 8'h07, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[10] = '{4'd4, 4'd5,  32'h0B000000, 32'hC0A80106, 8'h06, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[11] = '{4'd0, 4'd0,  32'h0A010203, 32'hC0A80107, 8'h11, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[12] = '{4'd4, 4'd5,  32'h0AFFFFFF, 32'hC0A80107, 8'h11, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[13] = '{4'd4, 4'd5,  32'h09FFFFFF, 32'hC0A80107, 8'h06, 1'b0, 1'b1, 3'd1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            send_hdr(mk_hdr(vecs[i].ver, vecs[i].ihl, vecs[i].src, vecs[i].dst, vecs[i].proto),
                     pack_exp(vecs[i].acc, vecs[i].hit, vecs[i].idx, vecs[i].bad));
        end
        drain();

        // backpressure: two headers fill the pipe, then s_ready must drop
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            h = mk_hdr(vecs[i].ver, vecs[i].ihl, vecs[i].src, vecs[i].dst, vecs[i].proto);
            send_hdr(h, model(h));
        end
        @(negedge clk);
        check("bp_s_ready_low", 64'(s_ready), 64'd0);
        check("bp_m_valid_high", 64'(m_valid), 64'd1);
        @(posedge clk); #1;
        fork
            begin
                logic [159:0] hb;
                for (int i = 2; i < 6; i++) begin
                    hb = mk_hdr(vecs[i].ver, vecs[i].ihl, vecs[i].src, vecs[i].dst, vecs[i].proto);
                    send_hdr(hb, model(hb));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain();

        // random burst with random downstream stalls
        burst_done = 0;
        fork
            begin
                logic [159:0] hr;
                logic [31:0] src, dst;
                logic [7:0] proto;
                for (int n = 0; n < 60; n++) begin
                    case ($urandom_range(0, 3))
                        0: src = {8'h0A, 24'($urandom())};
                        1: src = 32'hC0000201;
                        2: src = 32'h0B000001;
                        default: src = $urandom();
                    endcase
                    dst = ($urandom_range(0, 1) == 0) ? 32'hC0A80107 : $urandom();
                    case ($urandom_range(0, 2))
                        0: proto = 8'h06;
                        1: proto = 8'h11;
                        default: proto = 8'($urandom_range(0, 255));
                    endcase
                    hr = mk_hdr(($urandom_range(0, 7) == 0) ? 4'd6 : 4'd4,
                                4'($urandom_range(3, 15)), src, dst, proto);
                    send_hdr(hr, model(hr));
                end
                burst_done = 1;
            end
            begin
                while (!burst_done) begin
                    @(posedge clk); #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready = 1'b1;
        drain();

`ifdef IPV4_RULE_FILTER_STATS_EN
        @(negedge clk);
        check("accept_cnt", 64'(accept_cnt), 64'(n_acc));
        check("drop_cnt", 64'(drop_cnt), 64'(n_drop));
        check("bad_hdr_cnt", 64'(bad_hdr_cnt), 64'(n_bad));
        @(posedge clk); #1;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        @(negedge clk);
        check("stats_clr_accept", 64'(accept_cnt), 64'd0);
        check("stats_clr_drop", 64'(drop_cnt), 64'd0);
        check("stats_clr_bad", 64'(bad_hdr_cnt), 64'd0);
        n_acc = 0; n_drop = 0; n_bad = 0;
        @(posedge clk); #1;
`endif

        // reset with two headers in flight: neither may produce a verdict
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            h = mk_hdr(vecs[i].ver, vecs[i].ihl, vecs[i].src, vecs[i].dst, vecs[i].proto);
            send_hdr(h, model(h));
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        shadow_clear();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_no_verdict", 64'(m_valid), 64'd0);
            check("post_reset_s_ready", 64'(s_ready), 64'd1);
        end
        @(posedge clk); #1;
        h = mk_hdr(vecs[1].ver, vecs[1].ihl, vecs[1].src, vecs[1].dst, vecs[1].proto);
        send_hdr(h, pack_exp(1'b0, 1'b0, '0, 1'b0));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
